// File: rtl/sram_bist.sv
// SRAM self-test master: fills [ADR_LO, ADR_HI] with a selectable pattern over a
// Wishbone-style pipelined master port, reads it back, and reports pass/fail status,
// a saturating error count and the first failing address/data.
module sram_bist #(
   parameter int unsigned AW     = 19,
   parameter int unsigned DW     = 16,
   parameter int unsigned ADR_LO = 0,
   parameter int unsigned ADR_HI = (1 << AW) - 1,
   parameter int unsigned ECW    = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [1:0]      mode_i,
   input  logic            loop_i,
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o,
   output logic [DW/8-1:0] sel_o,
   output logic [AW:1]     adr_o,
   output logic [DW-1:0]   dat_o,
   input  logic            ack_i,
   input  logic [DW-1:0]   dat_i,
   input  logic            stall_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            fail_o,
   output logic [ECW-1:0]  err_cnt_o,
   output logic [AW-1:0]   err_adr_o,
   output logic [DW-1:0]   err_dat_o,
   output logic [7:0]      pass_cnt_o
);

   localparam logic [AW-1:0] AdrLo = AW'(ADR_LO);
   localparam logic [AW-1:0] AdrHi = AW'(ADR_HI);

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrAck,
      StRdReq,
      StRdAck,
      StDone
   } state_e;

   state_e        state_q;
   logic [1:0]    mode_q;
   logic [AW-1:0] adr_nxt;

   // Test pattern for word address a under the given mode.
   function automatic logic [DW-1:0] pattern(input logic [1:0] mode, input logic [AW-1:0] a);
      logic [31:0] ai;
      ai = 32'(a);
      case (mode)
         2'd0:    pattern = DW'(a);
         2'd1:    pattern = ~(DW'(a));
         2'd2:    pattern = DW'(1) << (ai % DW);
         default: pattern = a[1] ? {(DW/2){2'b01}} : {(DW/2){2'b10}};
      endcase
   endfunction

   // Byte selects are only meaningful while a request is presented.
   assign sel_o   = {(DW/8){stb_o}};
   assign adr_nxt = adr_o + AW'(1);

   // Test sequencer; every bus and status output is registered here.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         mode_q     <= 2'd0;
         cyc_o      <= 1'b0;
         stb_o      <= 1'b0;
         we_o       <= 1'b0;
         adr_o      <= '0;
         dat_o      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         fail_o     <= 1'b0;
         err_cnt_o  <= '0;
         err_adr_o  <= '0;
         err_dat_o  <= '0;
         pass_cnt_o <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  mode_q     <= mode_i;
                  fail_o     <= 1'b0;
                  err_cnt_o  <= '0;
                  err_adr_o  <= '0;
                  err_dat_o  <= '0;
                  pass_cnt_o <= 8'd0;
                  done_o     <= 1'b0;
                  busy_o     <= 1'b1;
                  cyc_o      <= 1'b1;
                  stb_o      <= 1'b1;
                  we_o       <= 1'b1;
                  adr_o      <= AdrLo;
                  dat_o      <= pattern(mode_i, AdrLo);
                  state_q    <= StWrReq;
               end
            end
            StWrReq: begin
               if (!stall_i) begin
                  stb_o   <= 1'b0;
                  state_q <= StWrAck;
               end
            end
            StWrAck: begin
               if (ack_i) begin
                  stb_o <= 1'b1;
                  if (adr_o == AdrHi) begin
                     adr_o   <= AdrLo;
                     we_o    <= 1'b0;
                     dat_o   <= '0;
                     state_q <= StRdReq;
                  end else begin
                     adr_o   <= adr_nxt;
                     dat_o   <= pattern(mode_q, adr_nxt);
                     state_q <= StWrReq;
                  end
               end
            end
            StRdReq: begin
               if (!stall_i) begin
                  stb_o   <= 1'b0;
                  state_q <= StRdAck;
               end
            end
            StRdAck: begin
               if (ack_i) begin
                  if (dat_i != pattern(mode_q, adr_o)) begin
                     fail_o <= 1'b1;
                     if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + ECW'(1);
                     end
                     // Only the first mismatch since start is recorded.
                     if (!fail_o) begin
                        err_adr_o <= adr_o;
                        err_dat_o <= dat_i;
                     end
                  end
                  if (adr_o == AdrHi) begin
                     cyc_o   <= 1'b0;
                     state_q <= StDone;
                  end else begin
                     stb_o   <= 1'b1;
                     adr_o   <= adr_nxt;
                     state_q <= StRdReq;
                  end
               end
            end
            StDone: begin
               pass_cnt_o <= pass_cnt_o + 8'd1;
               done_o     <= 1'b1;
               if (loop_i) begin
                  // Errors accumulate across looped passes.
                  cyc_o   <= 1'b1;
                  stb_o   <= 1'b1;
                  we_o    <= 1'b1;
                  adr_o   <= AdrLo;
                  dat_o   <= pattern(mode_q, AdrLo);
                  state_q <= StWrReq;
               end else begin
                  busy_o  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
